conv1_window_gen: RTL and testbench



---
 rtl/lenet_pkg.sv | 20 ++
 rtl/conv1_line_buffer.sv | 27 ++
 rtl/conv1_window_gen.sv | 131 +++++++++++++
 tb/tb_conv1_window_gen.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/lenet_pkg.sv
// Shared constants and types for the LeNet datapath blocks.
package lenet_pkg;

    // Pixel and kernel geometry shared by every convolution stage.
    localparam int DW = 16;
    localparam int K  = 5;

    // Per-layer input image sizes.
    localparam int C1_IMG_W = 32;
    localparam int C1_IMG_H = 32;
    localparam int C3_IMG_W = 14;
    localparam int C3_IMG_H = 14;

    // Flattened KxK window word width.
    localparam int WIN_W = K * K * DW;

    // Signed fixed-point pixel; window generators pass it through untouched.
    typedef logic signed [DW-1:0] pixel_t;

endpackage

// File: rtl/conv1_line_buffer.sv
// Single-row delay line: the output is the pixel accepted DEPTH enables ago.
// Data storage is deliberately not reset; it is refilled before it is used.
module conv1_line_buffer #(
    parameter int DEPTH = 32,
    parameter int DW    = 16
) (
    input  logic          clk,
    input  logic          en,
    input  logic [DW-1:0] din,
    output logic [DW-1:0] dout
);

    logic [DW-1:0] mem [DEPTH];

    // Shift one position per accepted pixel; gaps freeze the line.
    always_ff @(posedge clk) begin
        if (en) begin
            mem[0] <= din;
            for (int i = 1; i < DEPTH; i++) begin
                mem[i] <= mem[i-1];
            end
        end
    end

    assign dout = mem[DEPTH-1];

endmodule

// File: rtl/conv1_window_gen.sv
// KxK sliding-window generator feeding the first LeNet convolution stage.
//
// Handshake: in_valid qualifies in_pixel and in_sof for exactly that cycle;
// there is no ready, every valid pixel is accepted. out_valid is a one-cycle
// strobe qualifying out_window; the consumer must take every strobe.
module conv1_window_gen
    import lenet_pkg::*;
#(
    parameter int IMG_W = C1_IMG_W,
    parameter int IMG_H = C1_IMG_H,
    parameter int K     = lenet_pkg::K,
    parameter int DW    = lenet_pkg::DW
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              in_valid,
    input  logic              in_sof,
    input  logic [DW-1:0]     in_pixel,
    output logic              out_valid,
    output logic [K*K*DW-1:0] out_window,
    output logic              frame_done
);

    localparam int CW = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam int RW = (IMG_H > 1) ? $clog2(IMG_H) : 1;

    localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
    localparam logic [CW-1:0] COL_MIN  = CW'(K - 1);
    localparam logic [RW-1:0] ROW_MIN  = RW'(K - 1);

    // Position of the next pixel to be accepted.
    logic [CW-1:0] col;
    logic [RW-1:0] row;

    // Position of the pixel on the input this cycle (sof forces origin).
    logic [CW-1:0] cur_col, nxt_col;
    logic [RW-1:0] cur_row, nxt_row;
    logic          last_col, last_row, eligible;

    logic [DW-1:0]     tap     [K-1];
    logic [DW-1:0]     win     [K][K];
    logic [DW-1:0]     win_nxt [K][K];
    logic [K*K*DW-1:0] win_flat;

    // Resolve the current pixel position and the following one.
    always_comb begin
        cur_col  = in_sof ? '0 : col;
        cur_row  = in_sof ? '0 : row;
        last_col = (cur_col == COL_LAST);
        last_row = (cur_row == ROW_LAST);
        eligible = (cur_col >= COL_MIN) && (cur_row >= ROW_MIN);
        nxt_col  = last_col ? '0 : cur_col + CW'(1);
        nxt_row  = cur_row;
        if (last_col) begin
            nxt_row = last_row ? '0 : cur_row + RW'(1);
        end
    end

    // Chain of K-1 row delays; line j holds the row j+1 above the input.
    for (genvar j = 0; j < K - 1; j++) begin : g_line
        if (j == 0) begin : g_first
            conv1_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_line (
                .clk  (clk),
                .en   (in_valid),
                .din  (in_pixel),
                .dout (tap[j])
            );
        end else begin : g_next
            conv1_line_buffer #(.DEPTH(IMG_W), .DW(DW)) u_line (
                .clk  (clk),
                .en   (in_valid),
                .din  (tap[j-1]),
                .dout (tap[j])
            );
        end
    end

    // Next window: shift left one column, insert the new right-hand column
    // with the oldest buffered row at the top.
    always_comb begin
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K - 1; c++) begin
                win_nxt[r][c] = win[r][c+1];
            end
        end
        for (int r = 0; r < K - 1; r++) begin
            win_nxt[r][K-1] = tap[K-2-r];
        end
        win_nxt[K-1][K-1] = in_pixel;
    end

    // Flatten the next window into the output word layout.
    always_comb begin
        win_flat = '0;
        for (int r = 0; r < K; r++) begin
            for (int c = 0; c < K; c++) begin
                win_flat[DW*(r*K+c) +: DW] = win_nxt[r][c];
            end
        end
    end

    // Window register advances on every accepted pixel; not reset.
    always_ff @(posedge clk) begin
        if (in_valid) begin
            win <= win_nxt;
        end
    end

    // Position counters, output strobe, window capture and frame-done pulse.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            col        <= '0;
            row        <= '0;
            out_valid  <= 1'b0;
            frame_done <= 1'b0;
            out_window <= '0;
        end else begin
            out_valid  <= in_valid && eligible;
            frame_done <= in_valid && last_col && last_row;
            if (in_valid) begin
                col <= nxt_col;
                row <= nxt_row;
                if (eligible) begin
                    out_window <= win_flat;
                end
            end
        end
    end

endmodule

// File: tb/tb_conv1_window_gen.sv
// Self-checking bench for conv1_window_gen: frames of ramp or random pixels,
// optional input gaps, mid-frame sof and mid-frame reset, checked against a
// frame-array reference model.
module tb_conv1_window_gen;

    localparam int W     = 32;
    localparam int H     = 32;
    localparam int K     = 5;
    localparam int DW    = 16;
    localparam int WIN_W = K * K * DW;
    localparam int NWIN  = (H - K + 1) * (W - K + 1);

    // ---------------- clock / reset ----------------
    logic             clk = 1'b0;
    logic             rstn;
    logic             in_valid;
    logic             in_sof;
    logic [DW-1:0]    in_pixel;
    logic             out_valid;
    logic [WIN_W-1:0] out_window;
    logic             frame_done;

    always #5 clk = ~clk;

    conv1_window_gen #(.IMG_W(W), .IMG_H(H), .K(K), .DW(DW)) dut (
        .clk        (clk),
        .rstn       (rstn),
        .in_valid   (in_valid),
        .in_sof     (in_sof),
        .in_pixel   (in_pixel),
        .out_valid  (out_valid),
        .out_window (out_window),
        .frame_done (frame_done)
    );

    // ---------------- reference model / scoreboard ----------------
    logic [DW-1:0]    img [H][W];
    logic [WIN_W-1:0] exp_q [$];
    int               m_row, m_col;
    logic             exp_valid, exp_done;
    logic [WIN_W-1:0] exp_hold;

    int               n_vec, n_err;
    int               n_valid, n_done;
    bit               got_first;
    logic [WIN_W-1:0] first_win, last_win;

    function automatic logic [WIN_W-1:0] build_win(int y, int x);
        logic [WIN_W-1:0] w;
        w = '0;
        for (int r = 0; r < K; r++)
            for (int c = 0; c < K; c++)
                w[DW*(r*K+c) +: DW] = img[y-K+1+r][x-K+1+c];
        return w;
    endfunction

    function automatic int elem(logic [WIN_W-1:0] w, int r, int c);
        return int'(w[DW*(r*K+c) +: DW]);
    endfunction

    task automatic chk_w(string tag, logic [WIN_W-1:0] got, logic [WIN_W-1:0] exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_i(string tag, int got, int exp);
        n_vec++;
        assert (got === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- driver ----------------
    // One clock: drive inputs, let the model predict, check after the edge.
    task automatic cycle(input bit v, input bit sof, input logic [DW-1:0] pix);
        logic [WIN_W-1:0] w;
        @(negedge clk);
        in_valid  = v;
        in_sof    = sof;
        in_pixel  = pix;
        exp_valid = 1'b0;
        exp_done  = 1'b0;
        if (!rstn) begin
            m_row    = 0;
            m_col    = 0;
            exp_hold = '0;
            exp_q.delete();
        end else if (v) begin
            if (sof) begin
                m_row = 0;
                m_col = 0;
            end
            img[m_row][m_col] = pix;
            if (m_row >= K - 1 && m_col >= K - 1) begin
                w = build_win(m_row, m_col);
                exp_q.push_back(w);
                exp_valid = 1'b1;
                exp_hold  = w;
            end
            if (m_row == H - 1 && m_col == W - 1) exp_done = 1'b1;
            m_col++;
            if (m_col == W) begin
                m_col = 0;
                m_row = (m_row + 1) % H;
            end
        end
        @(posedge clk);
        #1;
        chk_i("out_valid", int'(out_valid), int'(exp_valid));
        chk_i("frame_done", int'(frame_done), int'(exp_done));
        chk_w("out_window_held", out_window, exp_hold);
        if (frame_done) begin
            n_done++;
            chk_i("done_with_valid", int'(out_valid), 1);
        end
        if (out_valid) begin
            n_valid++;
            if (exp_q.size() == 0) begin
                chk_i("unexpected_window", 1, 0);
            end else begin
                w = exp_q.pop_front();
                chk_w("window", out_window, w);
            end
            if (!got_first) first_win = out_window;
            got_first = 1'b1;
            last_win  = out_window;
        end
    endtask

    // Send the first npix pixels of a frame; ramp = base + y*W + x.
    task automatic send_frame(int base, bit with_sof, int gap_pct, bit rnd, int npix);
        for (int k = 0; k < npix; k++) begin
            while (int'($urandom_range(99)) < gap_pct)
                cycle(1'b0, 1'($urandom_range(1)), DW'($urandom));
            cycle(1'b1, with_sof && (k == 0), rnd ? DW'($urandom) : DW'(base + k));
        end
    endtask

    task automatic clear_stats();
        n_valid   = 0;
        n_done    = 0;
        got_first = 1'b0;
    endtask

    task automatic check_ramp(string tag, int base);
        chk_i({tag, "_valids"}, n_valid, NWIN);
        chk_i({tag, "_done"}, n_done, 1);
        chk_i({tag, "_first00"}, elem(first_win, 0, 0), base + 0);
        chk_i({tag, "_first04"}, elem(first_win, 0, 4), base + 4);
        chk_i({tag, "_first40"}, elem(first_win, 4, 0), base + 128);
        chk_i({tag, "_first44"}, elem(first_win, 4, 4), base + 132);
        chk_i({tag, "_last00"}, elem(last_win, 0, 0), base + 891);
        chk_i({tag, "_last44"}, elem(last_win, 4, 4), base + 1023);
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int mn;
        n_vec = 0;
        n_err = 0;
        m_row = 0;
        m_col = 0;
        exp_hold = '0;
        rstn     = 1'b0;
        in_valid = 1'b0;
        in_sof   = 1'b0;
        in_pixel = '0;
        clear_stats();

        // Reset state.
        cycle(1'b0, 1'b0, '0);
        cycle(1'b1, 1'b1, 16'h1234);
        rstn = 1'b1;
        cycle(1'b0, 1'b0, '0);

        // Continuous ramp frame.
        clear_stats();
        send_frame(0, 1'b1, 0, 1'b0, W * H);
        check_ramp("ramp", 0);

        // Same ramp with ~50% input gaps.
        clear_stats();
        send_frame(0, 1'b1, 50, 1'b0, W * H);
        check_ramp("gaps", 0);

        // Back-to-back frames, second without sof and offset by 2000.
        clear_stats();
        send_frame(0, 1'b1, 0, 1'b0, W * H);
        chk_i("b2b_f1_valids", n_valid, NWIN);
        got_first = 1'b0;
        send_frame(2000, 1'b0, 0, 1'b0, W * H);
        chk_i("b2b_valids", n_valid, 2 * NWIN);
        chk_i("b2b_done", n_done, 2);
        chk_i("b2b_f2_first00", elem(first_win, 0, 0), 2000);
        chk_i("b2b_f2_first44", elem(first_win, 4, 4), 2132);
        mn = 65535;
        for (int i = 0; i < K * K; i++)
            if (int'(first_win[DW*i +: DW]) < mn) mn = int'(first_win[DW*i +: DW]);
        chk_i("b2b_f2_no_old", int'(mn >= 2000), 1);

        // Mid-frame sof at (10,7) followed by a full ramp.
        clear_stats();
        send_frame(5000, 1'b1, 0, 1'b0, 10 * W + 7);
        chk_i("abort_done", n_done, 0);
        clear_stats();
        send_frame(0, 1'b1, 0, 1'b0, W * H);
        check_ramp("after_sof", 0);

        // Reset for one cycle at (15,20), then a full ramp without sof.
        clear_stats();
        send_frame(7000, 1'b1, 0, 1'b0, 15 * W + 20);
        rstn = 1'b0;
        cycle(1'b1, 1'b0, DW'($urandom));
        rstn = 1'b1;
        clear_stats();
        send_frame(0, 1'b0, 0, 1'b0, W * H);
        check_ramp("after_rst", 0);

        // Random pixel frame with random gaps.
        clear_stats();
        send_frame(0, 1'b1, 30, 1'b1, W * H);
        chk_i("rand_valids", n_valid, NWIN);
        chk_i("rand_done", n_done, 1);
        chk_i("queue_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
